// File: rtl/ahb_lite_tmr_mem_bank.sv
// AHB-Lite responder for one redundant memory bank behind the TMR voter.
// Programmable wait states, two-cycle ERROR response, byte-lane writes and bit-flip injection.
module ahb_lite_tmr_mem_bank #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_WORDS   = 4096,
   parameter int WAIT_STATES = 0
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic                         HSEL,
   input  logic [ADDR_WIDTH-1:0]        HADDR,
   input  logic [1:0]                   HTRANS,
   input  logic                         HWRITE,
   input  logic [2:0]                   HSIZE,
   input  logic [2:0]                   HBURST,
   input  logic [DATA_WIDTH-1:0]        HWDATA,
   input  logic                         HREADY,
   output logic                         HREADYOUT,
   output logic                         HRESP,
   output logic [DATA_WIDTH-1:0]        HRDATA,
   input  logic                         inj_en,
   input  logic [$clog2(MEM_WORDS)-1:0] inj_addr,
   input  logic [4:0]                   inj_bit
);

   // state  | meaning
   // IDLE   | no beat in flight, ready
   // WAIT   | OKAY beat stalling, HREADYOUT=0 while counter runs down
   // DATA   | data phase: write commits at end of cycle, read data on HRDATA
   // ERR1   | first ERROR cycle (HREADYOUT=0, HRESP=1)
   // ERR2   | second ERROR cycle (HREADYOUT=1, HRESP=1)
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   localparam int                    IW         = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] LP_LIMIT   = ADDR_WIDTH'(MEM_WORDS * 4);
   localparam logic [2:0]            LP_WS_LOAD = 3'(WAIT_STATES - 1);

   state_t          r_state, w_next, w_go;
   logic [31:0]     r_mem [MEM_WORDS];
   logic [IW-1:0]   r_idx;
   logic [1:0]      r_lo;
   logic [1:0]      r_size;
   logic            r_write;
   logic [2:0]      r_cnt;
   logic            r_hreadyout;
   logic            r_hresp;
   logic [31:0]     r_hrdata;

   logic            w_accept, w_take, w_err, w_wr_en, w_rd_take, w_rd_wait;
   logic [IW-1:0]   w_haddr_idx, w_rd_idx;
   logic [3:0]      w_lanes;
   logic [31:0]     w_bitmask, w_merged, w_rd_word, w_inj_mask, w_inj_on_wr;
   logic            w_unused;

   assign w_unused    = ^{HBURST, HTRANS[0]};
   assign w_accept    = HSEL & HTRANS[1] & HREADY;
   assign w_haddr_idx = HADDR[IW+1:2];
   assign w_err       = (HADDR >= LP_LIMIT) || (HSIZE > 3'd2) ||
                        (HSIZE == 3'd1 && HADDR[0]) ||
                        (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
   assign w_go        = w_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);

   always_comb begin
      w_next = r_state;
      w_take = 1'b0;
      case (r_state)
         S_IDLE, S_DATA, S_ERR2: begin
            if (w_accept) begin
               w_take = 1'b1;
               w_next = w_go;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_WAIT:  if (r_cnt == 3'd0) w_next = S_DATA;
         S_ERR1:  w_next = S_ERR2;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_lanes = 4'b1111;
      case (r_size)
         2'd0:    w_lanes = 4'b0001 << r_lo;
         2'd1:    w_lanes = r_lo[1] ? 4'b1100 : 4'b0011;
         default: w_lanes = 4'b1111;
      endcase
   end

   assign w_bitmask   = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
   assign w_wr_en     = (r_state == S_DATA) && r_write;
   assign w_merged    = (r_mem[r_idx] & ~w_bitmask) | (HWDATA & w_bitmask);
   assign w_inj_mask  = 32'd1 << inj_bit;
   assign w_inj_on_wr = (inj_en && inj_addr == r_idx) ? w_inj_mask : 32'd0;

   // Read data is captured on the edge entering DATA; a write finishing on
   // that same edge has not reached the array yet, so forward its merged word.
   assign w_rd_take = w_take && (w_go == S_DATA) && !HWRITE;
   assign w_rd_wait = (r_state == S_WAIT) && (r_cnt == 3'd0) && !r_write;
   assign w_rd_idx  = w_rd_wait ? r_idx : w_haddr_idx;
   assign w_rd_word = (w_wr_en && r_idx == w_rd_idx) ? w_merged : r_mem[w_rd_idx];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_lo        <= 2'd0;
         r_size      <= 2'd0;
         r_write     <= 1'b0;
         r_cnt       <= 3'd0;
         r_hreadyout <= 1'b1;
         r_hresp     <= 1'b0;
         r_hrdata    <= 32'd0;
      end else begin
         r_state     <= w_next;
         r_hreadyout <= !(w_next == S_WAIT || w_next == S_ERR1);
         r_hresp     <= (w_next == S_ERR1 || w_next == S_ERR2);
         if (w_take) begin
            r_idx   <= w_haddr_idx;
            r_lo    <= HADDR[1:0];
            r_size  <= HSIZE[1:0];
            r_write <= HWRITE && !w_err;
            r_cnt   <= LP_WS_LOAD;
         end else if (r_state == S_WAIT && r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (w_rd_take || w_rd_wait) r_hrdata <= w_rd_word;
      end
   end

   // Array is not reset; a flip on the word being written lands on the new value.
   always_ff @(posedge HCLK) begin
      if (w_wr_en) r_mem[r_idx] <= w_merged ^ w_inj_on_wr;
      if (inj_en && !(w_wr_en && inj_addr == r_idx))
         r_mem[inj_addr] <= r_mem[inj_addr] ^ w_inj_mask;
   end

   assign HREADYOUT = r_hreadyout;
   assign HRESP     = r_hresp;
   assign HRDATA    = r_hrdata;

endmodule
